// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the strobe-fed UART transmitter.
//            Holds the transmitter state encoding, the frame length in bit
//            times and the width of the data-bit index.
// Config   : UART_PARITY_EN adds an even-parity bit (frame 11 bits vs 10).
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // Index over the 8 data bits of a character.
  localparam int BIT_IDX_W = 3;

  // Even parity: the XOR of all data bits.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_strobe_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_strobe_fifo
// Purpose  : Small synchronous FIFO queueing bytes between the strobe capture
//            and the UART serialiser. Pointers carry one extra wrap bit so
//            full and empty fall out of a pointer compare.
// Ports    : clk       - system clock, rising edge
//            nRst      - asynchronous active-low reset (clears pointers)
//            push      - write request; push_data is the byte to write
//            pop       - read request; pop_data shows the head entry
//            push_ok   - the write is taken this edge
//            full      - FIFO_DEPTH entries held
//            empty     - no entries held
//            level     - current occupancy, 0..FIFO_DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module uart_strobe_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          nRst,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         pop_data,
  output logic                          push_ok,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  pop_ok;

  assign empty    = (wr_ptr == rd_ptr);
  // Same slot index but different wrap bit: writer is one lap ahead.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok   = pop & ~empty;
  // A full FIFO still takes a write when an entry leaves on the same edge.
  assign push_ok  = push & (~full | pop_ok);
  assign level    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_strobe_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_strobe_tx
// Purpose  : Captures bytes qualified by the falling edge of an active-low
//            strobe, queues them and serialises them as asynchronous UART
//            frames (start, 8 data bits LSB first, [parity], stop).
// Config   : UART_PARITY_EN - when defined, an even-parity bit follows the
//            data bits (8E1, 11 bit times); otherwise 8N1 (10 bit times).
// Ports    : clk       - system clock, rising edge
//            nRst      - asynchronous active-low reset
//            nDValid   - active-low data strobe; one byte per falling edge
//            dIn       - byte sampled on the strobe's falling edge
//            txd       - UART line, idles high
//            busy      - frame in progress or bytes queued
//            overflow  - sticky: a byte arrived while the queue was full
//            fifoLevel - current queue occupancy
// Revision : 1.0 - initial release
// ============================================================================
module uart_strobe_tx
  import uart_pkg::*;
#(
  parameter int CLOCKFRQ   = 240000000,
  parameter int BAUDRATE   = 115200,
  parameter int DIVISOR    = CLOCKFRQ / BAUDRATE,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         nRst,
  input  logic                         nDValid,
  input  logic [DATA_WIDTH-1:0]        dIn,
  output logic                         txd,
  output logic                         busy,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifoLevel
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0]        CNT_LAST = CW'(DIVISOR - 1);
  localparam logic [BIT_IDX_W-1:0] BIT_LAST = BIT_IDX_W'(DATA_WIDTH - 1);

  generate
    if (DIVISOR < 2) begin : g_bad_divisor
      $error("uart_strobe_tx: DIVISOR must be at least 2");
    end
  endgenerate

  tx_state_t               state;
  logic [CW-1:0]           baud_cnt;
  logic [BIT_IDX_W-1:0]    bit_idx;
  logic [DATA_WIDTH-1:0]   shreg;
  logic                    ndv_q;
`ifdef UART_PARITY_EN
  logic                    par_bit;
`endif

  logic                    strobe;
  logic                    bit_end;
  logic                    pop;
  logic                    drop;
  logic                    push_ok;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [DATA_WIDTH-1:0]   fifo_data;
  logic [LW-1:0]           level_next;
  logic                    busy_next;

  // Falling edge of the strobe: low now, high on the previous sample.
  assign strobe  = ndv_q & ~nDValid;
  assign bit_end = (baud_cnt == CNT_LAST);

  // Load the next byte from idle, or straight out of a stop bit so that
  // queued frames follow each other with no idle gap.
  assign pop  = ~fifo_empty & ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));
  assign drop = strobe & fifo_full & ~pop;

  assign level_next = fifoLevel + LW'(push_ok) - LW'(pop);

  // Next-cycle view of (state != IDLE) || (level != 0), so the registered
  // busy flag lines up with the state and level it describes.
  assign busy_next = (level_next != '0) | pop |
                     ((state != ST_IDLE) & ~((state == ST_STOP) & bit_end));

  uart_strobe_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .nRst      (nRst),
    .push      (strobe),
    .push_data (dIn),
    .pop       (pop),
    .pop_data  (fifo_data),
    .push_ok   (push_ok),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifoLevel)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
      ndv_q    <= 1'b1;
`ifdef UART_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      ndv_q <= nDValid;
      busy  <= busy_next;
      if (drop) overflow <= 1'b1;

      // Every state change happens at a bit boundary, so wrapping the
      // counter at bit_end restarts it on each transition.
      if (state == ST_IDLE) baud_cnt <= '0;
      else                  baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (pop) begin
            state    <= ST_START;
            shreg    <= fifo_data;
            txd      <= 1'b0;
            baud_cnt <= '0;
`ifdef UART_PARITY_EN
            par_bit  <= even_parity(fifo_data);
`endif
          end
        end

        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            txd     <= shreg[0];
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == BIT_LAST) begin
`ifdef UART_PARITY_EN
              state <= ST_PARITY;
              txd   <= par_bit;
`else
              state <= ST_STOP;
              txd   <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {1'b0, shreg[DATA_WIDTH-1:1]};
              txd     <= shreg[1];
            end
          end
        end

`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            state <= ST_STOP;
            txd   <= 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (bit_end) begin
            if (pop) begin
              state <= ST_START;
              shreg <= fifo_data;
              txd   <= 1'b0;
`ifdef UART_PARITY_EN
              par_bit <= even_parity(fifo_data);
`endif
            end else begin
              state <= ST_IDLE;
              txd   <= 1'b1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
